// File: rtl/noc_pkg.sv
// Shared definitions for the router input port: header layout, port codes, FSM states.
package noc_pkg;

    localparam int DEST_MSB = 31;
    localparam int DEST_LSB = 24;
    localparam int TYPE_MSB = 23;
    localparam int TYPE_LSB = 21;
    localparam int RW_BIT   = 20;
    localparam int ADDR_MSB = 19;

    localparam logic [4:0] PORT_LOCAL = 5'b00001;
    localparam logic [4:0] PORT_NORTH = 5'b00010;
    localparam logic [4:0] PORT_EAST  = 5'b00100;
    localparam logic [4:0] PORT_SOUTH = 5'b01000;
    localparam logic [4:0] PORT_WEST  = 5'b10000;

    typedef enum logic [1:0] {
        HEAD = 2'd0,
        BODY = 2'd1,
        DROP = 2'd2
    } state_e;

    // Dimension-ordered routing: resolve X first, then Y, else deliver locally.
    function automatic logic [4:0] xy_route(input logic [3:0] dx, input logic [3:0] dy,
                                            input logic [3:0] mx, input logic [3:0] my);
        logic [4:0] p;
        if (dx > mx)      p = PORT_EAST;
        else if (dx < mx) p = PORT_WEST;
        else if (dy > my) p = PORT_SOUTH;
        else if (dy < my) p = PORT_NORTH;
        else              p = PORT_LOCAL;
        return p;
    endfunction

endpackage

// File: rtl/noc_flit_fifo.sv
// Synchronous flit FIFO; head is the oldest entry, valid one cycle after a push into empty.
module noc_flit_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic                  full,
    output logic                  empty,
    output logic [DATA_WIDTH-1:0] head
);
    localparam int AW = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW:0]           wr_ptr;
    logic [AW:0]           rd_ptr;
    logic [AW:0]           one;

    assign one   = {{AW{1'b0}}, 1'b1};
    // Extra pointer MSB distinguishes full from empty when the index bits match.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head  = mem[rd_ptr[AW-1:0]];

    // Storage write; contents need no reset since empty masks them.
    always_ff @(posedge clk) begin
        if (push && !full) mem[wr_ptr[AW-1:0]] <= wdata;
    end

    // Pointer update; a reset drops everything buffered.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) wr_ptr <= wr_ptr + one;
            if (pop && !empty) rd_ptr <= rd_ptr + one;
        end
    end

endmodule

// File: rtl/noc_router_input_port.sv
// Router input port: buffers flits, XY-routes the header and holds the route for the packet.
module noc_router_input_port
    import noc_pkg::*;
#(
    parameter int         DATA_WIDTH = 32,
    parameter int         FIFO_DEPTH = 4,
    parameter logic [7:0] NODE_ID    = 8'h00,
    parameter int         MESH_X     = 4,
    parameter int         MESH_Y     = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4:0]            out_port,
    output logic                  out_is_head,
    output logic                  out_is_tail,
    output logic [2:0]            out_msg_type,
    output logic                  err_pulse,
    output logic [15:0]           pkt_count,
    output logic [7:0]            drop_count
);
    state_e                state;
    logic [4:0]            route_reg;
    logic [2:0]            msg_type_reg;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [DATA_WIDTH-1:0] fifo_head;
    logic                  push;
    logic                  pop;
    logic                  hs;
    logic                  drop_pop;
    logic [3:0]            dest_x;
    logic [3:0]            dest_y;
    logic                  dest_ok;
    logic                  head_rw;
    logic                  active;

    assign in_ready = !fifo_full && !rst;
    assign push     = in_valid && in_ready;
    assign hs       = out_valid && out_ready;
    assign pop      = hs || drop_pop;
    assign active   = !rst && !fifo_empty;
    assign out_data = active ? fifo_head : '0;

    assign dest_x  = fifo_head[DEST_LSB+3:DEST_LSB];
    assign dest_y  = fifo_head[DEST_MSB:DEST_LSB+4];
    assign head_rw = fifo_head[RW_BIT];
    assign dest_ok = ({1'b0, dest_x} < 5'(MESH_X)) && ({1'b0, dest_y} < 5'(MESH_Y));

    noc_flit_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdata (in_data),
        .full  (fifo_full),
        .empty (fifo_empty),
        .head  (fifo_head)
    );

    // Per-state presentation to the switch; outputs derive only from FIFO head and latched route, so they hold under stall.
    always_comb begin
        out_valid    = 1'b0;
        out_port     = '0;
        out_is_head  = 1'b0;
        out_is_tail  = 1'b0;
        out_msg_type = '0;
        err_pulse    = 1'b0;
        drop_pop     = 1'b0;
        if (active) begin
            case (state)
                HEAD: begin
                    if (dest_ok) begin
                        out_valid    = 1'b1;
                        out_is_head  = 1'b1;
                        out_is_tail  = !head_rw;
                        out_port     = xy_route(dest_x, dest_y, NODE_ID[3:0], NODE_ID[7:4]);
                        out_msg_type = fifo_head[TYPE_MSB:TYPE_LSB];
                    end else begin
                        drop_pop  = 1'b1;
                        err_pulse = 1'b1;
                    end
                end
                BODY: begin
                    out_valid    = 1'b1;
                    out_is_tail  = 1'b1;
                    out_port     = route_reg;
                    out_msg_type = msg_type_reg;
                end
                DROP:    drop_pop = 1'b1;
                default: ;
            endcase
        end
    end

    // Packet FSM: wormhole route lock plus forwarded/dropped packet counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= HEAD;
            route_reg    <= '0;
            msg_type_reg <= '0;
            pkt_count    <= '0;
            drop_count   <= '0;
        end else begin
            case (state)
                HEAD: begin
                    if (hs) begin
                        route_reg    <= out_port;
                        msg_type_reg <= out_msg_type;
                        if (head_rw) state <= BODY;
                        else         pkt_count <= pkt_count + 16'd1;
                    end
                    if (drop_pop) begin
                        if (drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
                        if (head_rw) state <= DROP;
                    end
                end
                BODY: begin
                    if (hs) begin
                        pkt_count <= pkt_count + 16'd1;
                        state     <= HEAD;
                    end
                end
                DROP: begin
                    if (drop_pop) state <= HEAD;
                end
                default: state <= HEAD;
            endcase
        end
    end

endmodule

// File: tb/tb_noc_router_input_port.sv
// Directed bench for the router input port at node (1,1) of a 4x4 mesh.
module tb_noc_router_input_port;

    logic        clk;
    logic        rst;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  out_port;
    logic        out_is_head;
    logic        out_is_tail;
    logic [2:0]  out_msg_type;
    logic        err_pulse;
    logic [15:0] pkt_count;
    logic [7:0]  drop_count;

    int tests = 0;
    int fails = 0;

    noc_router_input_port #(
        .DATA_WIDTH (32),
        .FIFO_DEPTH (4),
        .NODE_ID    (8'h11),
        .MESH_X     (4),
        .MESH_Y     (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_port     (out_port),
        .out_is_head  (out_is_head),
        .out_is_tail  (out_is_tail),
        .out_msg_type (out_msg_type),
        .err_pulse    (err_pulse),
        .pkt_count    (pkt_count),
        .drop_count   (drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        tick();
        tick();
        chk("rst_in_ready", 32'(in_ready), 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_port", 32'(out_port), 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_err", 32'(err_pulse), 0);
        chk("rst_pkt", 32'(pkt_count), 0);
        chk("rst_drop", 32'(drop_count), 0);
        rst = 1'b0;
        tick();
        chk("idle_in_ready", 32'(in_ready), 1);
        chk("idle_out_valid", 32'(out_valid), 0);

        // Read to (2,2): EAST, single flit
        in_valid = 1'b1; in_data = 32'h22000100;
        tick();
        in_valid = 1'b0;
        chk("rd_valid", 32'(out_valid), 1);
        chk("rd_port", 32'(out_port), 32'b00100);
        chk("rd_head", 32'(out_is_head), 1);
        chk("rd_tail", 32'(out_is_tail), 1);
        chk("rd_data", out_data, 32'h22000100);
        tick();
        chk("rd_pkt", 32'(pkt_count), 1);
        chk("rd_empty", 32'(out_valid), 0);

        // Write to (0,1): WEST, payload stalled three cycles
        in_valid = 1'b1; in_data = 32'h10300040;
        tick();
        in_data = 32'hDEADBEEF;
        chk("wr_h_port", 32'(out_port), 32'b10000);
        chk("wr_h_tail", 32'(out_is_tail), 0);
        chk("wr_h_head", 32'(out_is_head), 1);
        chk("wr_h_type", 32'(out_msg_type), 1);
        tick();
        in_valid = 1'b0; out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("wr_p_valid", 32'(out_valid), 1);
            chk("wr_p_port", 32'(out_port), 32'b10000);
            chk("wr_p_data", out_data, 32'hDEADBEEF);
            chk("wr_p_tail", 32'(out_is_tail), 1);
            chk("wr_p_head", 32'(out_is_head), 0);
            chk("wr_p_type", 32'(out_msg_type), 1);
            chk("wr_p_pkt", 32'(pkt_count), 1);
            if (i == 2) out_ready = 1'b1;
            tick();
        end
        chk("wr_pkt", 32'(pkt_count), 2);
        chk("wr_done", 32'(out_valid), 0);

        // LOCAL then NORTH
        in_valid = 1'b1; in_data = 32'h11000000;
        tick();
        in_data = 32'h01000000;
        chk("local_port", 32'(out_port), 32'b00001);
        tick();
        in_valid = 1'b0;
        chk("north_port", 32'(out_port), 32'b00010);
        tick();
        chk("ln_pkt", 32'(pkt_count), 4);

        // Write to invalid (1,5) gets dropped with its payload
        in_valid = 1'b1; in_data = 32'h51100000;
        tick();
        in_data = 32'h12345678;
        chk("drop_h_valid", 32'(out_valid), 0);
        chk("drop_h_err", 32'(err_pulse), 1);
        tick();
        in_valid = 1'b0;
        chk("drop_p_valid", 32'(out_valid), 0);
        chk("drop_p_err", 32'(err_pulse), 0);
        chk("drop_cnt", 32'(drop_count), 1);
        tick();
        chk("drop_after_valid", 32'(out_valid), 0);
        chk("drop_after_err", 32'(err_pulse), 0);
        chk("drop_after_cnt", 32'(drop_count), 1);
        // Read to (1,3): SOUTH
        in_valid = 1'b1; in_data = 32'h31000000;
        tick();
        in_valid = 1'b0;
        chk("south_valid", 32'(out_valid), 1);
        chk("south_port", 32'(out_port), 32'b01000);
        tick();
        chk("south_pkt", 32'(pkt_count), 5);

        // Backpressure: four fit, fifth waits for space
        out_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            in_valid = 1'b1; in_data = 32'h11000000 + 32'(i);
            tick();
        end
        in_data = 32'h11000005;
        chk("full_in_ready", 32'(in_ready), 0);
        tick();
        chk("full_hold_ready", 32'(in_ready), 0);
        chk("full_head", out_data, 32'h11000001);
        out_ready = 1'b1;
        tick();
        chk("drain_ready", 32'(in_ready), 1);
        chk("drain_f2", out_data, 32'h11000002);
        tick();
        in_valid = 1'b0;
        chk("drain_f3", out_data, 32'h11000003);
        tick();
        chk("drain_f4", out_data, 32'h11000004);
        tick();
        chk("drain_f5", out_data, 32'h11000005);
        tick();
        chk("drain_empty", 32'(out_valid), 0);
        chk("drain_pkt", 32'(pkt_count), 10);

        // Reset in BODY with two flits buffered
        in_valid = 1'b1; in_data = 32'h22100000;
        tick();
        in_data = 32'hAAAA0001;
        tick();
        out_ready = 1'b0;
        in_data = 32'h22000002;
        tick();
        in_valid = 1'b0;
        chk("body_valid", 32'(out_valid), 1);
        chk("body_head", 32'(out_is_head), 0);
        chk("body_port", 32'(out_port), 32'b00100);
        rst = 1'b1;
        #1;
        chk("midrst_valid", 32'(out_valid), 0);
        chk("midrst_in_ready", 32'(in_ready), 0);
        tick();
        rst = 1'b0; out_ready = 1'b1;
        #1;
        chk("postrst_valid", 32'(out_valid), 0);
        chk("postrst_data", out_data, 0);
        chk("postrst_pkt", 32'(pkt_count), 0);
        chk("postrst_drop", 32'(drop_count), 0);
        chk("postrst_ready", 32'(in_ready), 1);
        tick();
        in_valid = 1'b1; in_data = 32'h22000000;
        tick();
        in_valid = 1'b0;
        chk("postrst_is_head", 32'(out_is_head), 1);
        chk("postrst_port", 32'(out_port), 32'b00100);
        tick();
        chk("postrst_pkt1", 32'(pkt_count), 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
